// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide engine owning the HI/LO registers.
// Latency: 34 cycles start-to-done (32 RUN + 1 FIX); busy stalls EX meanwhile.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_ex,
  input  logic             div_ex,
  input  logic             signed_ex,
  input  logic             mthi_ex,
  input  logic             mtlo_ex,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 start, commit;
  logic [CNT_W-1:0]     cnt;
  logic                 is_mul, a_neg, b_neg, dz;
  logic [WIDTH-1:0]     a_raw, opb;
  logic [2*WIDTH-1:0]   acc;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_top, div_trial;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (mult_ex || div_ex) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush)             state_nxt = IDLE;
        else if (cnt == '0)    state_nxt = FIX;
      end
      FIX: begin
        commit    = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign abs_a = (signed_ex && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (signed_ex && src_b[WIDTH-1]) ? -src_b : src_b;

  // Shift-add: upper half accumulates, multiplier bits drain out of the lower half.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, opb} & {(WIDTH+1){acc[0]}});
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: partial remainder < divisor, so a 33-bit trial never wraps.
  assign div_top   = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_top - {1'b0, opb};
  assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (is_mul) begin
      {fix_hi, fix_lo} = (a_neg ^ b_neg) ? -acc : acc;
    end else if (dz) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_lo = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      is_mul      <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz          <= 1'b0;
      a_raw       <= '0;
      opb         <= '0;
      acc         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt    <= CNT_W'(WIDTH - 1);
        is_mul <= mult_ex;
        a_neg  <= signed_ex & src_a[WIDTH-1];
        b_neg  <= signed_ex & src_b[WIDTH-1];
        dz     <= !mult_ex && (src_b == '0);
        a_raw  <= src_a;
        if (mult_ex) begin
          acc <= {{WIDTH{1'b0}}, abs_b};
          opb <= abs_a;
        end else begin
          acc <= {{WIDTH{1'b0}}, abs_a};
          opb <= abs_b;
        end
      end else if (state == IDLE) begin
        if (mthi_ex) hi_out <= src_a;
        if (mtlo_ex) lo_out <= src_a;
      end else if (state == RUN && !flush) begin
        cnt <= cnt - CNT_W'(1);
        acc <= is_mul ? mul_step : div_step;
      end else if (commit) begin
        res_hi      <= fix_hi;
        res_lo      <= fix_lo;
        hi_out      <= fix_hi;
        lo_out      <= fix_lo;
        done        <= 1'b1;
        div_by_zero <= !is_mul && dz;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle-level arithmetic model plus literal checks.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_ex, div_ex, signed_ex, mthi_ex, mtlo_ex, flush;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [31:0] res_hi, res_lo, hi_out, lo_out;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .mult_ex(mult_ex), .div_ex(div_ex), .signed_ex(signed_ex),
    .mthi_ex(mthi_ex), .mtlo_ex(mtlo_ex), .flush(flush),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .res_hi(res_hi), .res_lo(res_lo), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model_op(input logic mul, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (mul) begin
      p = 64'(sa * sb);
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    return {1'b0, r, q};
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_res_hi = '0, m_res_lo = '0, m_hi = '0, m_lo = '0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0; m_done <= 1'b0; m_dz <= 1'b0;
      m_res_hi <= '0; m_res_lo <= '0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (mult_ex || div_ex) begin
          m_pend <= model_op(mult_ex, signed_ex, src_a, src_b);
          m_left <= 33;
        end else begin
          if (mthi_ex) m_hi <= src_a;
          if (mtlo_ex) m_lo <= src_a;
        end
      end else if (flush) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left   <= 0;
        m_done   <= 1'b1;
        m_dz     <= m_pend[64];
        m_res_hi <= m_pend[63:32];
        m_res_lo <= m_pend[31:0];
        m_hi     <= m_pend[63:32];
        m_lo     <= m_pend[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   64'(busy),        64'(m_left != 0));
      check("cyc_done",   64'(done),        64'(m_done));
      check("cyc_dz",     64'(div_by_zero), 64'(m_dz));
      check("cyc_res_hi", 64'(res_hi),      64'(m_res_hi));
      check("cyc_res_lo", 64'(res_lo),      64'(m_res_lo));
      check("cyc_hi_out", 64'(hi_out),      64'(m_hi));
      check("cyc_lo_out", 64'(lo_out),      64'(m_lo));
    end
  end

  // Issues one start in cycle t; inj pulses mtlo_ex/div_ex in cycle t+inj,
  // fl_at asserts flush in cycle t+fl_at (0 disables either).
  task automatic run_op(input string nm, input logic mul, input logic dv, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input int inj, input int fl_at);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    mult_ex = mul; div_ex = dv; signed_ex = sgn; src_a = a; src_b = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fl_at > 0 && i == fl_at + 1) check({nm, "_busy_after_flush"}, 64'(busy), 64'd0);
      if (inj == 0 && fl_at == 0 && i >= 1 && i <= 33) check({nm, "_busy_win"}, 64'(busy), 64'd1);
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
      mult_ex = 1'b0;
      div_ex  = (i + 1 == inj);
      mtlo_ex = (i + 1 == inj);
      flush   = (i + 1 == fl_at);
      if (i + 1 == inj) src_a = 32'hDEAD_BEEF;
    end
    mult_ex = 1'b0; div_ex = 1'b0; mtlo_ex = 1'b0; flush = 1'b0;
    if (fl_at > 0) begin
      check({nm, "_no_done"}, 64'(lat < 0), 64'd1);
    end else begin
      check({nm, "_latency"}, 64'(lat), 64'd34);
      check({nm, "_res_hi"},  64'(res_hi), 64'(eh));
      check({nm, "_res_lo"},  64'(res_lo), 64'(el));
      check({nm, "_hi_out"},  64'(hi_out), 64'(eh));
      check({nm, "_lo_out"},  64'(lo_out), 64'(el));
      check({nm, "_dz"},      64'(div_by_zero), 64'(edz));
    end
  endtask

  initial begin
    reset = 1'b1;
    mult_ex = 1'b0; div_ex = 1'b0; signed_ex = 1'b0;
    mthi_ex = 1'b0; mtlo_ex = 1'b0; flush = 1'b0;
    src_a = '0; src_b = '0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_by_zero), 64'd0);
    check("rst_res",  {res_hi, res_lo}, 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);

    @(posedge clk); #1;
    mthi_ex = 1'b1; src_a = 32'h0000_1234;
    @(posedge clk); #1;
    mthi_ex = 1'b0;
    check("mthi_hi_out", 64'(hi_out), 64'h1234);
    check("mthi_busy",   64'(busy), 64'd0);
    check("mthi_lo_keep", 64'(lo_out), 64'd0);

    @(posedge clk); #1;
    mthi_ex = 1'b1; mtlo_ex = 1'b1; src_a = 32'hCAFE_0001;
    @(posedge clk); #1;
    mthi_ex = 1'b0; mtlo_ex = 1'b0;
    check("mt_both", {hi_out, lo_out}, 64'hCAFE_0001_CAFE_0001);

    run_op("multu_max", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0);
    run_op("mult_neg",  1, 0, 1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0);
    run_op("div_neg",   0, 1, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
    run_op("divu",      0, 1, 0, 32'd100,       32'd7,         32'd2,         32'd14,        0, 0, 0);
    run_op("div_ovf",   0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, 0, 0);
    run_op("divu_zero", 0, 1, 0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1, 0, 0);
    run_op("div_zneg",  0, 1, 1, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("div_inj",   0, 1, 0, 32'd100,       32'd7,         32'd2,         32'd14,        0, 10, 0);
    run_op("both",      1, 1, 0, 32'd5,         32'd3,         32'd0,         32'd15,        0, 0, 0);
    run_op("flush",     1, 0, 0, 32'd2,         32'd3,         32'd0,         32'd0,         0, 0, 10);
    check("flush_hilo_keep", {hi_out, lo_out}, 64'h0000_0000_0000_000F);
    check("flush_res_keep",  {res_hi, res_lo}, 64'h0000_0000_0000_000F);

    @(posedge clk); #1;
    mult_ex = 1'b1; signed_ex = 1'b0; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1;
    mult_ex = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_dz",   64'(div_by_zero), 64'd0);
    check("rstmid_res",  {res_hi, res_lo}, 64'd0);
    check("rstmid_hilo", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    run_op("mult_post", 1, 0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd0, 32'd15, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32×32 multiply/divide engine in the EX stage. It owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the EX stage and raises a stall request while an operation is in flight. It publishes completed results (`res_hi`/`res_lo`) and the committed HI/LO values (`hi_out`/`lo_out`) to the forwarding unit downstream.

## Interface
Parameters:
- `WIDTH`, 32, operand width (fixed at 32 for this core).
- `CNT_W`, 5, iteration counter width (log2 WIDTH).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mult_ex`  in  1  start multiply; sampled only in IDLE.
- `div_ex`  in  1  start divide; sampled only in IDLE.
- `signed_ex`  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- `mthi_ex`  in  1  write `src_a` into HI.
- `mtlo_ex`  in  1  write `src_a` into LO.
- `flush`  in  1  abort the in-flight operation.
- `src_a`  in  32  multiplicand / dividend / MTHI-MTLO data.
- `src_b`  in  32  multiplier / divisor.
- `busy`  out  1  stall request; high while state ≠ IDLE.
- `done`  out  1  one-cycle registered completion pulse.
- `div_by_zero`  out  1  registered; valid with `done` for a divide.
- `res_hi`  out  32  last completed HI result (registered).
- `res_lo`  out  32  last completed LO result (registered).
- `hi_out`  out  32  architectural HI.
- `lo_out`  out  32  architectural LO.

## Operation
FSM states: IDLE, RUN, FIX.

- **IDLE, accepting a start.** If `mult_ex|div_ex`, the FSM latches the operation, the sign flags, and the absolute values of the operands (absolute only when `signed_ex`). It sets `cnt=31` and moves to RUN. Multiply has priority if both starts are high; the accepted operation is then a multiply.
- **IDLE, MTHI/MTLO.** With no start pending, `mthi_ex`/`mtlo_ex` write `src_a` to `hi_out`/`lo_out` at the next edge. Both may be asserted in the same cycle. A start in the same cycle wins and the MT write is dropped.
- **RUN, multiply.** One iteration per cycle using shift-add on a 64-bit accumulator.
- **RUN, divide.** One iteration per cycle using restoring division: 64-bit remainder/quotient register, trial subtract of the 33-bit divisor.
- **RUN, exit.** After 32 iterations (`cnt==0` edge), the FSM moves to FIX.
- **FIX, multiply sign.** If the operand signs differ, negate the 64-bit product.
- **FIX, divide sign.** Negate the quotient if the signs differ. Give the remainder the dividend's sign. Quotient truncates toward zero.
- **FIX, commit.** Write `res_hi`/`res_lo` and `hi_out`/`lo_out`, pulse `done`, and return to IDLE.
- **Divide by zero** (`src_b==0`, sampled at start): runs the full latency. Result is `lo=32'hFFFFFFFF`, `hi=src_a`, `div_by_zero=1`.
- **Signed overflow** (`0x80000000 / 0xFFFFFFFF`): `lo=0x80000000`, `hi=0`, no flag.
- **Width rule.** Product is the full 64-bit value: `hi=[63:32]`, `lo=[31:0]`. For divide, `lo`=quotient and `hi`=remainder.
- **Inputs while busy.** `mult_ex`/`div_ex`/`mthi_ex`/`mtlo_ex` are ignored in RUN/FIX; the hazard unit holds the instruction.
- **Flush.** `flush` in RUN or FIX returns the FSM to IDLE at the next edge. No `done`, no change to `res_*` or `hi_out`/`lo_out`.
- **Reset.** Asserting `reset` at any time, mid-operation included, forces IDLE immediately and clears everything.

## Timing
- **Reset values.** `busy=0`, `done=0`, `div_by_zero=0`, `res_hi=res_lo=0`, `hi_out=lo_out=0`, state IDLE.
- **Start.** Accepted in cycle t.
- **Busy window.** `busy` is high in cycles t+1 through t+33: 32 RUN cycles plus 1 FIX cycle.
- **Completion.** `done`, `res_*` and `hi_out`/`lo_out` carry the new values in cycle t+34. This is the first cycle the forwarding unit may bypass `res_hi`/`res_lo`.
- **Back-to-back.** The next start is accepted in cycle t+34, so back-to-back throughput is one operation per 34 cycles.
- **MTHI/MTLO.** Issued in cycle t, visible on `hi_out`/`lo_out` in t+1; `busy` stays low.
- **Done pulse.** `done` is exactly one cycle wide. `div_by_zero` holds until the next `done`.
- **Flush timing.** `flush` in cycle k of RUN makes `busy` low in k+1.

## Test plan
- MULTU `0xFFFFFFFF × 0xFFFFFFFF` at t → `busy` high t+1..t+33; `done` at t+34 with `hi=0xFFFFFFFE`, `lo=0x00000001`.
- MULT `-3 × 7` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`.
- DIV `-7 / 2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- DIVU `100 / 7` → `lo=14`, `hi=2`.
- DIV `0x80000000 / 0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
- DIVU `5 / 0` → `lo=0xFFFFFFFF`, `hi=5`, `div_by_zero=1`, `done` at t+34.
- Start MULTU `2×3`, assert `flush` at t+10 → `busy` low at t+11, no `done`, `hi_out`/`lo_out` keep prior values. Repeat with `reset` low at t+10 → all outputs 0 immediately.
- MTHI `0x1234` in IDLE → `hi_out=0x1234` next cycle, `busy` stays 0.
- Pulse `mtlo_ex` and `div_ex` mid-RUN → both ignored.
- Assert `mult_ex` and `div_ex` together with `5, 3` → `lo=15`, `hi=0`.
